// File: rtl/pipelined_divider_hs.sv
// Pipelined unsigned restoring divider with valid/ready handshakes and a sideband tag.
// Define DIVIDER_REMAINDER_EN to carry the remainder to remainder_out; otherwise it is tied to 0.
module pipelined_divider_hs #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_STAGE = 2,
    parameter int unsigned TAG_WIDTH      = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [WIDTH-1:0]     dividend_in,
    input  logic [WIDTH-1:0]     divisor_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [WIDTH-1:0]     quotient_out,
    output logic [WIDTH-1:0]     remainder_out,
    output logic                 div_zero_out,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    localparam int unsigned LAT        = (WIDTH + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
    localparam int unsigned LAST_STEPS = WIDTH - (LAT - 1) * BITS_PER_STAGE;

`ifdef DIVIDER_REMAINDER_EN
    localparam bit KEEP_REM = 1'b1;
`else
    localparam bit KEEP_REM = 1'b0;
`endif

    logic                 stall;
    logic                 accept_en_q;
    logic                 v_q   [LAT];
    logic [WIDTH:0]       p_q   [LAT];
    logic [WIDTH-1:0]     dq_q  [LAT];
    logic [WIDTH-1:0]     dv_q  [LAT];
    logic [TAG_WIDTH-1:0] tag_q [LAT];
    logic                 dz_q  [LAT];

    // dq holds the unconsumed dividend bits at the top and the quotient bits shifted in at the bottom.
    function automatic logic [2*WIDTH:0] div_steps(
        input logic [WIDTH:0]   p,
        input logic [WIDTH-1:0] dq,
        input logic [WIDTH-1:0] dv,
        input int unsigned      n
    );
        logic [WIDTH:0]   pp;
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] qq;
        pp = p;
        qq = dq;
        for (int unsigned k = 0; k < BITS_PER_STAGE; k++) begin
            if (k < n) begin
                t  = {pp[WIDTH-1:0], qq[WIDTH-1]};
                qq = {qq[WIDTH-2:0], 1'b0};
                if (t >= {1'b0, dv}) begin
                    t     = t - {1'b0, dv};
                    qq[0] = 1'b1;
                end
                pp = t;
            end
        end
        return {pp, qq};
    endfunction

    // ready_out stays low until the first edge after reset release.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) accept_en_q <= 1'b0;
        else           accept_en_q <= 1'b1;
    end

    assign stall     = v_q[LAT-1] && !ready_in;
    assign ready_out = accept_en_q && !stall;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        logic                 v_src;
        logic                 dz_src;
        logic [WIDTH:0]       p_src;
        logic [WIDTH-1:0]     dq_src;
        logic [WIDTH-1:0]     dv_src;
        logic [TAG_WIDTH-1:0] tag_src;
        logic [2*WIDTH:0]     nxt;

        if (s == 0) begin : g_head
            assign v_src   = valid_in && ready_out;
            assign p_src   = '0;
            assign dq_src  = dividend_in;
            assign dv_src  = divisor_in;
            assign tag_src = tag_in;
            assign dz_src  = (divisor_in == '0);
        end else begin : g_body
            assign v_src   = v_q[s-1];
            assign p_src   = p_q[s-1];
            assign dq_src  = dq_q[s-1];
            assign dv_src  = dv_q[s-1];
            assign tag_src = tag_q[s-1];
            assign dz_src  = dz_q[s-1];
        end

        assign nxt = div_steps(p_src, dq_src, dv_src,
                               (s == LAT - 1) ? LAST_STEPS : BITS_PER_STAGE);

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                v_q[s]   <= 1'b0;
                dq_q[s]  <= '0;
                dv_q[s]  <= '0;
                tag_q[s] <= '0;
                dz_q[s]  <= 1'b0;
            end else if (!stall) begin
                v_q[s]   <= v_src;
                dq_q[s]  <= nxt[WIDTH-1:0];
                dv_q[s]  <= dv_src;
                tag_q[s] <= tag_src;
                dz_q[s]  <= dz_src;
            end
        end

        // The last stage keeps the partial remainder only when it is exported.
        if (KEEP_REM || (s < LAT - 1)) begin : g_rem
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in)   p_q[s] <= '0;
                else if (!stall) p_q[s] <= nxt[2*WIDTH:WIDTH];
            end
        end else begin : g_no_rem
            assign p_q[s] = '0;
        end
    end

    assign valid_out     = v_q[LAT-1];
    assign quotient_out  = dq_q[LAT-1];
    assign remainder_out = p_q[LAT-1][WIDTH-1:0];
    assign div_zero_out  = dz_q[LAT-1];
    assign tag_out       = tag_q[LAT-1];

endmodule

// File: tb/tb_pipelined_divider_hs.sv
// Self-checking bench: two divider configurations (16/2 and 14/3) against a queue-based arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_divider_hs;

    localparam int unsigned WA = 16, BA = 2, LA = 8;
    localparam int unsigned WB = 14, BB = 3, LB = 5;
    localparam int unsigned N_RAND = 3000;

    typedef struct {
        int unsigned q;
        int unsigned r;
        bit          dz;
        int unsigned tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [WA-1:0] dvdA = '0, dvsA = '0, qoA, roA;
    logic [7:0]    tagA = '0, toA;
    logic          viA = 1'b0, riA = 1'b0, voA, rdyoA, dzA;

    logic [WB-1:0] dvdB = '0, dvsB = '0, qoB, roB;
    logic [7:0]    tagB = '0, toB;
    logic          viB = 1'b0, riB = 1'b0, voB, rdyoB, dzB;

    always #5 clk = ~clk;

    pipelined_divider_hs #(.WIDTH(WA), .BITS_PER_STAGE(BA), .TAG_WIDTH(8)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n),
        .dividend_in(dvdA), .divisor_in(dvsA), .tag_in(tagA), .valid_in(viA), .ready_out(rdyoA),
        .quotient_out(qoA), .remainder_out(roA), .div_zero_out(dzA), .tag_out(toA),
        .valid_out(voA), .ready_in(riA)
    );

    pipelined_divider_hs #(.WIDTH(WB), .BITS_PER_STAGE(BB), .TAG_WIDTH(8)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n),
        .dividend_in(dvdB), .divisor_in(dvsB), .tag_in(tagB), .valid_in(viB), .ready_out(rdyoB),
        .quotient_out(qoB), .remainder_out(roB), .div_zero_out(dzB), .tag_out(toB),
        .valid_out(voB), .ready_in(riB)
    );

    int tests = 0;
    int fails = 0;
    exp_t qa[$];
    exp_t qb[$];
    int unsigned accA = 0, accB = 0;
    bit rdy_ok;

    function automatic exp_t model(input int unsigned w, input int unsigned a,
                                   input int unsigned b, input int unsigned t);
        exp_t e;
        int unsigned m;
        m    = (32'd1 << w) - 32'd1;
        e.dz = (b == 0);
        e.q  = (b == 0) ? m : a / b;
`ifdef DIVIDER_REMAINDER_EN
        e.r  = (b == 0) ? a : a % b;
`else
        e.r  = 0;
`endif
        e.tag = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned rand_dvs(input int unsigned w);
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 0;
        if (sel == 1) return 1;
        if (sel == 2) return $urandom_range(1, 15);
        return $urandom & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic int unsigned rand_dvd(input int unsigned w);
        if ($urandom_range(0, 7) == 0) return (32'd1 << w) - 32'd1;
        return $urandom & ((32'd1 << w) - 32'd1);
    endfunction

    // Spec-level ready: high from the first edge after reset release, low while stalled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_ok <= 1'b0;
        else        rdy_ok <= 1'b1;
    end

    exp_t ea, eb;
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            chk("ready_a", 64'(rdyoA), 64'(rdy_ok && !(voA && !riA)));
            if (voA) begin
                chk("a_pending", 64'(qa.size() != 0), 64'(1));
                if (qa.size() != 0) begin
                    ea = qa[0];
                    chk("quot_a", 64'(qoA), 64'(ea.q));
                    chk("rem_a",  64'(roA), 64'(ea.r));
                    chk("dz_a",   64'(dzA), 64'(ea.dz));
                    chk("tag_a",  64'(toA), 64'(ea.tag));
                    if (riA) void'(qa.pop_front());
                end
            end
            if (viA && rdyoA) begin
                qa.push_back(model(WA, 32'(dvdA), 32'(dvsA), 32'(tagA)));
                accA++;
            end

            chk("ready_b", 64'(rdyoB), 64'(rdy_ok && !(voB && !riB)));
            if (voB) begin
                chk("b_pending", 64'(qb.size() != 0), 64'(1));
                if (qb.size() != 0) begin
                    eb = qb[0];
                    chk("quot_b", 64'(qoB), 64'(eb.q));
                    chk("rem_b",  64'(roB), 64'(eb.r));
                    chk("dz_b",   64'(dzB), 64'(eb.dz));
                    chk("tag_b",  64'(toB), 64'(eb.tag));
                    if (riB) void'(qb.pop_front());
                end
            end
            if (viB && rdyoB) begin
                qb.push_back(model(WB, 32'(dvdB), 32'(dvsB), 32'(tagB)));
                accB++;
            end
        end
    end

    // Single directed operation with hand-computed expectations and latency in edges.
    task automatic op(input bit sel, input int unsigned dvd, input int unsigned dvs,
                      input int unsigned tg, input int unsigned eq, input int unsigned er,
                      input int unsigned edz, input int unsigned elat);
        int n;
        logic v;
        int unsigned er_eff;
`ifdef DIVIDER_REMAINDER_EN
        er_eff = er;
`else
        er_eff = 0;
`endif
        @(posedge clk); #1;
        if (!sel) begin
            dvdA = WA'(dvd); dvsA = WA'(dvs); tagA = 8'(tg); viA = 1'b1; riA = 1'b1;
        end else begin
            dvdB = WB'(dvd); dvsB = WB'(dvs); tagB = 8'(tg); viB = 1'b1; riB = 1'b1;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            viA = 1'b0; viB = 1'b0;
            n++;
            v = sel ? voB : voA;
        end while (!v && n < 20);
        chk(sel ? "lat_b" : "lat_a", 64'(n), 64'(elat));
        chk(sel ? "lit_q_b" : "lit_q_a",     sel ? 64'(qoB) : 64'(qoA), 64'(eq));
        chk(sel ? "lit_r_b" : "lit_r_a",     sel ? 64'(roB) : 64'(roA), 64'(er_eff));
        chk(sel ? "lit_dz_b" : "lit_dz_a",   sel ? 64'(dzB) : 64'(dzA), 64'(edz));
        chk(sel ? "lit_tag_b" : "lit_tag_a", sel ? 64'(toB) : 64'(toA), 64'(tg));
    endtask

    task automatic stream_a(input int cnt, input int unsigned tbase);
        @(posedge clk); #1;
        riA = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            dvdA = WA'(rand_dvd(WA)); dvsA = WA'($urandom_range(1, 300));
            tagA = 8'(tbase + 32'(i)); viA = 1'b1;
            @(posedge clk); #1;
        end
        viA = 1'b0;
    endtask

    task automatic wait_valid_a();
        int n;
        n = 0;
        while (!voA && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_valid_a", 64'(voA), 64'(1));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(qa.size() + qb.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_a", 64'(voA), 64'(0));
        chk("rst_quot_a",  64'(qoA), 64'(0));
        chk("rst_rem_a",   64'(roA), 64'(0));
        chk("rst_dz_a",    64'(dzA), 64'(0));
        chk("rst_tag_a",   64'(toA), 64'(0));
        chk("rst_ready_a", 64'(rdyoA), 64'(0));
        chk("rst_valid_b", 64'(voB), 64'(0));
        chk("rst_ready_b", 64'(rdyoB), 64'(0));

        @(posedge clk); #1;
        rst_n = 1'b1;
        #2;
        chk("ready_before_edge", 64'(rdyoA), 64'(0));
        @(posedge clk); #1;
        chk("ready_after_edge", 64'(rdyoA), 64'(1));

        op(1'b0, 1000, 7, 8'h11, 142, 6, 0, LA);
        op(1'b0, 65535, 1, 8'h22, 65535, 0, 0, LA);
        op(1'b0, 5, 0, 8'h33, 16'hFFFF, 5, 1, LA);
        op(1'b1, 9999, 99, 8'h5A, 101, 0, 0, LB);
        op(1'b1, 7, 0, 8'h5B, 14'h3FFF, 7, 1, LB);
        wait_drain("drain_directed");

        // Back-to-back stream: results must come out on consecutive cycles.
        stream_a(8, 0);
        wait_valid_a();
        n = 0;
        while (voA && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("stream_run_len", 64'(n), 64'(8));
        wait_drain("drain_stream");

        // Backpressure: hold the output for three cycles.
        stream_a(8, 32'h20);
        wait_valid_a();
        riA = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("stall_ready", 64'(rdyoA), 64'(0));
            chk("stall_valid", 64'(voA), 64'(1));
            if (qa.size() != 0) begin
                chk("stall_quot", 64'(qoA), 64'(qa[0].q));
                chk("stall_tag",  64'(toA), 64'(qa[0].tag));
            end
            @(posedge clk); #1;
        end
        riA = 1'b1;
        wait_drain("drain_stall");

        // Asynchronous reset with operations in flight.
        stream_a(4, 32'h40);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(voA), 64'(0));
        chk("async_rst_ready", 64'(rdyoA), 64'(0));
        chk("async_rst_tag",   64'(toA), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (voA || voB) n++;
        end
        chk("post_reset_quiet", 64'(n), 64'(0));

        // Randomized traffic with random backpressure on both configurations.
        accA = 0; accB = 0;
        cyc = 0;
        while ((accA < N_RAND || accB < N_RAND) && cyc < 40000) begin
            viA  = (accA < N_RAND) && ($urandom_range(0, 3) != 0);
            dvdA = WA'(rand_dvd(WA)); dvsA = WA'(rand_dvs(WA)); tagA = 8'($urandom);
            riA  = ($urandom_range(0, 9) < 7);
            viB  = (accB < N_RAND) && ($urandom_range(0, 3) != 0);
            dvdB = WB'(rand_dvd(WB)); dvsB = WB'(rand_dvs(WB)); tagB = 8'($urandom);
            riB  = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_budget", 64'(cyc < 40000), 64'(1));
        viA = 1'b0; viB = 1'b0; riA = 1'b1; riB = 1'b1;
        wait_drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
